ascon_state_shift_out: RTL and testbench

- Serial read-out engine for the Ascon permutation state. It is the reader counterpart of the permutation block's bit-serial state shift-in port.
- On a start request it snapshots the five 64-bit state words S_0..S_4. It then presents either one selected word or all five words MSB-first, one bit per shift strobe from the peripheral (e.g. SPI).
- The bit order is chosen so that looping the output into the shift-in port (which appends at the LSB) reproduces each word exactly.

---
 rtl/ascon_state_shift_out_if.sv | 31 +++
 rtl/ascon_state_shift_out.sv | 126 ++++++++++++
 tb/tb_ascon_state_shift_out.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_state_shift_out_if.sv
`default_nettype none
// ============================================================================
// Module      : ascon_state_shift_out_if
// Description : Control and bit-serial handshake bundle for the Ascon state
//               read-out engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface ascon_state_shift_out_if;
   logic       start;
   logic       all_words;
   logic [2:0] word_sel;
   logic       abort;
   logic       shift_en;
   logic       shift_msb;
   logic       shift_valid;
   logic [2:0] shift_word;
   logic       busy;
   logic       done;
   logic       sel_err;

   modport master (
      output start, all_words, word_sel, abort, shift_en,
      input  shift_msb, shift_valid, shift_word, busy, done, sel_err
   );

   modport slave (
      input  start, all_words, word_sel, abort, shift_en,
      output shift_msb, shift_valid, shift_word, busy, done, sel_err
   );
endinterface
`default_nettype wire

// File: rtl/ascon_state_shift_out.sv
`default_nettype none
// ============================================================================
// Module      : ascon_state_shift_out
// Description : Snapshots the five Ascon state words and shifts one or all of
//               them out MSB-first, one bit per peripheral strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_state_shift_out #(
   parameter int WORD_W    = 64,
   parameter int NUM_WORDS = 5
) (
   input  wire logic              clk,
   input  wire logic              rst,
   ascon_state_shift_out_if.slave bus,
   input  wire logic [WORD_W-1:0] S_0_reg,
   input  wire logic [WORD_W-1:0] S_1_reg,
   input  wire logic [WORD_W-1:0] S_2_reg,
   input  wire logic [WORD_W-1:0] S_3_reg,
   input  wire logic [WORD_W-1:0] S_4_reg
);

   localparam int                c_bit_w    = $clog2(WORD_W);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WORD_W - 1);
   localparam logic [2:0]         c_last_idx = 3'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [WORD_W-1:0]  r_snap [NUM_WORDS];
   logic [c_bit_w-1:0] r_bit_ctr;
   logic [2:0]         r_word_ctr;
   logic [2:0]         r_last_word;
   logic               r_sel_err;

   state_t             w_state_nx;
   logic [c_bit_w-1:0] w_bit_nx;
   logic [2:0]         w_word_nx;
   logic [2:0]         w_last_nx;
   logic               w_sel_err_nx;
   logic               w_capture;
   logic               w_sel_bad;
   logic [c_bit_w-1:0] w_bit_idx;

   assign w_sel_bad = !bus.all_words && (bus.word_sel > c_last_idx);
   // MSB-first so a receiver appending at the LSB rebuilds the word unchanged
   assign w_bit_idx = c_bit_last - r_bit_ctr;

   always_comb begin
      w_state_nx   = r_state;
      w_bit_nx     = r_bit_ctr;
      w_word_nx    = r_word_ctr;
      w_last_nx    = r_last_word;
      w_sel_err_nx = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (w_sel_bad) begin
                  w_sel_err_nx = 1'b1;
               end else begin
                  w_capture  = 1'b1;
                  w_bit_nx   = '0;
                  w_word_nx  = bus.all_words ? 3'd0 : bus.word_sel;
                  w_last_nx  = bus.all_words ? c_last_idx : bus.word_sel;
                  w_state_nx = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            if (bus.abort) begin
               w_state_nx = ST_IDLE;
            end else if (bus.shift_en) begin
               if (r_bit_ctr != c_bit_last) begin
                  w_bit_nx = r_bit_ctr + 1'b1;
               end else if (r_word_ctr < r_last_word) begin
                  w_word_nx = r_word_ctr + 3'd1;
                  w_bit_nx  = '0;
               end else begin
                  w_state_nx = ST_DONE;
               end
            end
         end
         ST_DONE: w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_bit_ctr   <= '0;
         r_word_ctr  <= '0;
         r_last_word <= '0;
         r_sel_err   <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            r_snap[k] <= '0;
         end
      end else begin
         r_state     <= w_state_nx;
         r_bit_ctr   <= w_bit_nx;
         r_word_ctr  <= w_word_nx;
         r_last_word <= w_last_nx;
         r_sel_err   <= w_sel_err_nx;
         if (w_capture) begin
            r_snap[0] <= S_0_reg;
            r_snap[1] <= S_1_reg;
            r_snap[2] <= S_2_reg;
            r_snap[3] <= S_3_reg;
            r_snap[4] <= S_4_reg;
         end
      end
   end

   assign bus.shift_valid = (r_state == ST_SHIFT);
   assign bus.busy        = (r_state == ST_SHIFT);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.sel_err     = r_sel_err;
   assign bus.shift_word  = (r_state == ST_SHIFT) ? r_word_ctr : 3'd0;
   assign bus.shift_msb   = (r_state == ST_SHIFT) && r_snap[r_word_ctr][w_bit_idx];

endmodule
`default_nettype wire

// File: tb/tb_ascon_state_shift_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_state_shift_out
// Description : Self-checking bench for the Ascon state read-out engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_state_shift_out;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s [5];

   always #5 clk = ~clk;

   ascon_state_shift_out_if bus ();

   ascon_state_shift_out #(.WORD_W(64), .NUM_WORDS(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .S_0_reg (s[0]),
      .S_1_reg (s[1]),
      .S_2_reg (s[2]),
      .S_3_reg (s[3]),
      .S_4_reg (s[4])
   );

   // Reference: a queue of {word, bit} still owed to the reader
   typedef struct packed {
      logic [2:0] w;
      logic       b;
   } bit_t;

   bit_t        q [$];
   bit          m_active, m_done, m_sel;
   logic [63:0] snap [5];
   logic [63:0] dest [5];
   logic        lb_valid = 1'b0, lb_msb = 1'b0;
   logic [2:0]  lb_word = 3'd0;
   int          checks = 0, failures = 0;

   typedef struct {
      bit         all;
      logic [2:0] sel;
      bit         exp_err;
      int         exp_strobes;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic rand_state();
      for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
   endtask

   task automatic model_step();
      if (rst) begin
         q.delete();
         m_active = 0; m_done = 0; m_sel = 0;
      end else if (m_done) begin
         m_done = 0; m_sel = 0;
      end else if (m_active) begin
         m_sel = 0;
         if (bus.abort) begin
            q.delete();
            m_active = 0;
         end else if (bus.shift_en) begin
            if (lb_valid) dest[lb_word] = {dest[lb_word][62:0], lb_msb};
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end else begin
         m_sel = 0;
         if (bus.start) begin
            if (!bus.all_words && bus.word_sel > 3'd4) begin
               m_sel = 1;
            end else begin
               for (int k = 0; k < 5; k++) snap[k] = s[k];
               for (int k = 0; k < 5; k++) begin
                  if (bus.all_words || bus.word_sel == 3'(k))
                     for (int i = 63; i >= 0; i--) q.push_back({3'(k), s[k][i]});
               end
               m_active = 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("busy",        bus.busy,        m_active);
      chk("shift_valid", bus.shift_valid, m_active);
      chk("done",        bus.done,        m_done);
      chk("sel_err",     bus.sel_err,     m_sel);
      if (m_active) begin
         chk("shift_msb",  bus.shift_msb,  q[0].b);
         chk("shift_word", bus.shift_word, q[0].w);
      end else if (!m_done) begin
         chk("idle_msb", bus.shift_msb, 1'b0);
      end
      lb_valid = bus.shift_valid;
      lb_msb   = bus.shift_msb;
      lb_word  = bus.shift_word;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic set_idle();
      bus.start = 0; bus.all_words = 0; bus.word_sel = 0;
      bus.abort = 0; bus.shift_en = 0;
   endtask

   task automatic pulse_start(input bit all, input logic [2:0] sel);
      bus.start = 1; bus.all_words = all; bus.word_sel = sel;
      cycle();
      bus.start = 0;
   endtask

   initial begin
      int n, busy_cnt;
      bit got_done;

      vecs[0] = '{1'b1, 3'd0, 1'b0, 320};
      vecs[1] = '{1'b0, 3'd0, 1'b0, 64};
      vecs[2] = '{1'b0, 3'd4, 1'b0, 64};
      vecs[3] = '{1'b0, 3'd5, 1'b1, 0};
      vecs[4] = '{1'b0, 3'd7, 1'b1, 0};
      vecs[5] = '{1'b0, 3'd2, 1'b0, 64};

      set_idle();
      rand_state();
      rst = 1;
      cycle();
      cycle();
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_valid", bus.shift_valid, 1'b0);
      chk("rst_word", bus.shift_word, 3'd0);
      chk("rst_msb", bus.shift_msb, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_sel_err", bus.sel_err, 1'b0);
      rst = 0;
      cycle();

      foreach (vecs[v]) begin
         rand_state();
         for (int k = 0; k < 5; k++) dest[k] = '0;
         pulse_start(vecs[v].all, vecs[v].sel);
         chk("tbl_sel_err", bus.sel_err, vecs[v].exp_err);
         chk("tbl_busy", bus.busy, !vecs[v].exp_err);
         n = 0;
         got_done = 0;
         for (int c = 0; c < 1500 && !got_done; c++) begin
            bus.shift_en = $urandom_range(0, 1);
            if (bus.shift_en && bus.busy) n++;
            rand_state();
            cycle();
            if (bus.done) got_done = 1;
         end
         bus.shift_en = 0;
         chk("tbl_strobes", n, vecs[v].exp_strobes);
         chk("tbl_done", got_done, !vecs[v].exp_err);
         if (vecs[v].all)
            for (int k = 0; k < 5; k++) chk("loopback", dest[k], snap[k]);
         cycle();
      end

      // Single word 2, strobe held high
      s[2] = 64'h8000_0000_0000_0001;
      pulse_start(0, 3'd2);
      chk("sw_first_bit", bus.shift_msb, 1'b1);
      bus.shift_en = 1;
      busy_cnt = 1;
      got_done = 0;
      for (int c = 0; c < 100 && !got_done; c++) begin
         cycle();
         if (bus.busy) busy_cnt++;
         if (bus.done) got_done = 1;
      end
      bus.shift_en = 0;
      chk("sw_busy_cycles", busy_cnt, 64);
      chk("sw_done", got_done, 1'b1);
      cycle();

      // Abort after 10 strobes, abort beats a simultaneous strobe
      pulse_start(0, 3'd1);
      bus.shift_en = 1;
      repeat (10) cycle();
      bus.abort = 1;
      cycle();
      bus.abort = 0;
      bus.shift_en = 0;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      cycle();
      chk("abort_done_late", bus.done, 1'b0);

      // Start inside SHIFT must not restart or re-capture
      rand_state();
      pulse_start(1, 3'd0);
      bus.shift_en = 1;
      repeat (5) cycle();
      bus.shift_en = 0;
      rand_state();
      bus.start = 1; bus.all_words = 0; bus.word_sel = 3'd3;
      cycle();
      bus.start = 0;
      chk("mid_start_word", bus.shift_word, 3'd0);
      chk("mid_start_msb", bus.shift_msb, snap[0][58]);
      bus.abort = 1;
      cycle();
      bus.abort = 0;

      // Reset in the middle of an all-words transfer
      rand_state();
      pulse_start(1, 3'd0);
      bus.shift_en = 1;
      repeat (100) cycle();
      rst = 1;
      cycle();
      rst = 0;
      bus.shift_en = 0;
      chk("rstmid_busy", bus.busy, 1'b0);
      chk("rstmid_word", bus.shift_word, 3'd0);
      chk("rstmid_msb", bus.shift_msb, 1'b0);
      cycle();
      chk("rstmid_done", bus.done, 1'b0);
      rand_state();
      pulse_start(1, 3'd0);
      chk("rstmid_restart_word", bus.shift_word, 3'd0);
      chk("rstmid_restart_msb", bus.shift_msb, snap[0][63]);
      bus.abort = 1;
      cycle();
      bus.abort = 0;

      // Random traffic against the reference queue
      for (int c = 0; c < 6000; c++) begin
         bus.start     = ($urandom_range(0, 29) == 0);
         bus.all_words = $urandom_range(0, 1);
         bus.word_sel  = 3'($urandom_range(0, 7));
         bus.abort     = ($urandom_range(0, 299) == 0);
         bus.shift_en  = $urandom_range(0, 1);
         rst           = ($urandom_range(0, 999) == 0);
         rand_state();
         cycle();
      end
      set_idle();
      rst = 0;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
